cmac_core_done_tracker: RTL and testbench
=========================================

CMAC_CORE_DONE_TRACKER -- requirements
Module: cmac_core_done_tracker

Interface
REQ-001 SHALL provide parameter DRAIN_CYC, default 4, legal range 1..7: cycles waited after the final output before done is signalled.
REQ-002 SHALL provide parameter CNT_W, default 22: width of the output-atomic counter and of the programmed total.
REQ-003 nvdla_core_clk  input  1  core clock; all state updates on its rising edge.
REQ-004 nvdla_core_rstn  input  1  reset, asynchronous, active-low.
REQ-005 reg2dp_op_en  input  1  layer operation enable, level from the register file.
REQ-006 reg2dp_atomics_total  input  CNT_W  number of output atomics in the layer, minus one; sampled at start.
REQ-007 mac_out_pvld  input  1  one output atomic leaves the MAC array this cycle.
REQ-008 mac_out_layer_end  input  1  qualifies mac_out_pvld; marks the last atomic of the layer.
REQ-009 dp2reg_done  output  1  one-cycle layer-complete pulse, consumed by the CMAC config stage.
REQ-010 core_busy  output  1  high in states RUN and DRAIN.
REQ-011 dp2reg_out_cnt  output  CNT_W  atomics counted in the current or most recent layer.
REQ-012 dp2reg_err  output  1  sticky protocol-error flag for the current or most recent layer.

Function
REQ-013 SHALL register op_en_d1 <= reg2dp_op_en and done_d1 <= dp2reg_done every cycle.
REQ-014 SHALL define start = reg2dp_op_en & (~op_en_d1 | done_d1), evaluated only in IDLE.
REQ-015 SHALL implement FSM states IDLE, RUN, DRAIN, DONE; reset state IDLE.
REQ-016 IDLE -> RUN on start: latch total_q <= reg2dp_atomics_total, clear cnt to 0, clear dp2reg_err.
REQ-017 RUN: each cycle with mac_out_pvld=1 SHALL increment cnt by 1.
REQ-018 RUN -> DRAIN in the cycle mac_out_pvld=1 with cnt == total_q; cnt takes total_q+1 in that edge; drain counter loads DRAIN_CYC-1.
REQ-019 DRAIN SHALL decrement the drain counter each cycle; DRAIN -> DONE when it equals 0.
REQ-020 DONE SHALL assert dp2reg_done for exactly one cycle, then go to IDLE unconditionally.
REQ-021 Latency: final mac_out_pvld at cycle N SHALL produce dp2reg_done at cycle N+DRAIN_CYC+1.
REQ-022 mac_out_layer_end=1 with cnt != total_q in RUN SHALL set dp2reg_err; counting continues.
REQ-023 Final atomic (cnt == total_q) arriving with mac_out_layer_end=0 SHALL set dp2reg_err; completion proceeds normally.
REQ-024 mac_out_pvld=1 in IDLE, DRAIN or DONE SHALL set dp2reg_err and SHALL NOT change cnt.
REQ-025 cnt SHALL NOT wrap; total_q = all-ones completes at the all-ones atomic, cnt saturating at all-ones.
REQ-026 reg2dp_op_en deassertion during RUN/DRAIN SHALL NOT abort the layer.
REQ-027 reg2dp_op_en held high through done SHALL restart in the cycle after DONE (done_d1 term) with a fresh total sample.
REQ-028 dp2reg_out_cnt and dp2reg_err SHALL hold their values in IDLE until the next start.

Reset
REQ-029 On nvdla_core_rstn low, asynchronously: state IDLE, cnt 0, total_q 0, drain counter 0, op_en_d1 0, done_d1 0.
REQ-030 Reset values: dp2reg_done 0, core_busy 0, dp2reg_out_cnt 0, dp2reg_err 0.
REQ-031 Reset mid-layer SHALL discard the layer; no dp2reg_done until a new start after release.

Verification
REQ-032 op_en 0->1, total=3, four pvld at cycles 10-13 (layer_end on the 4th) -> dp2reg_done at cycle 18 (DRAIN_CYC=4), out_cnt=4, err=0.
REQ-033 total=5, layer_end on the 3rd pvld -> err=1 after that cycle; done still follows the 6th pvld by 5 cycles.
REQ-034 op_en held high across two layers (total=0 then total=1) -> two done pulses; the second start occurs in the cycle after the first done.
REQ-035 pvld in IDLE -> err=1, out_cnt unchanged, busy=0.
REQ-036 rstn pulsed low in DRAIN -> all outputs 0 immediately; no done pulse; the next op_en rise runs a clean layer.
REQ-037 DRAIN_CYC=1 and 7 with total=0 -> done exactly 2 and 8 cycles after the single pvld.

Source files
------------

// File: rtl/cmac_core_done_tracker_if.sv
// Handshake/status bundle between the CMAC register file, the MAC array
// output and the layer done tracker.
interface cmac_core_done_tracker_if #(
  parameter int CNT_W = 22
);
  logic             reg2dp_op_en;
  logic [CNT_W-1:0] reg2dp_atomics_total;
  logic             mac_out_pvld;
  logic             mac_out_layer_end;
  logic             dp2reg_done;
  logic             core_busy;
  logic [CNT_W-1:0] dp2reg_out_cnt;
  logic             dp2reg_err;

  // Driver side: register file / MAC array, observes status.
  modport master (
    output reg2dp_op_en,
    output reg2dp_atomics_total,
    output mac_out_pvld,
    output mac_out_layer_end,
    input  dp2reg_done,
    input  core_busy,
    input  dp2reg_out_cnt,
    input  dp2reg_err
  );

  // Tracker side.
  modport slave (
    input  reg2dp_op_en,
    input  reg2dp_atomics_total,
    input  mac_out_pvld,
    input  mac_out_layer_end,
    output dp2reg_done,
    output core_busy,
    output dp2reg_out_cnt,
    output dp2reg_err
  );
endinterface

// File: rtl/cmac_core_done_tracker.sv
// Layer completion tracker for the CMAC core: counts output atomics leaving
// the MAC array, waits a fixed drain interval after the final one, then
// pulses done. Protocol violations raise a sticky per-layer error flag.
module cmac_core_done_tracker #(
  parameter int DRAIN_CYC = 4,
  parameter int CNT_W     = 22
) (
  input  logic                        nvdla_core_clk,
  input  logic                        nvdla_core_rstn,
  cmac_core_done_tracker_if.slave     bus
);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  localparam logic [2:0] DRAIN_LOAD = 3'(DRAIN_CYC - 1);

  state_t           state_q;
  logic             op_en_d1_q;
  logic             done_d1_q;
  logic             done_q;
  logic             busy_q;
  logic             err_q;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] total_q;
  logic [2:0]       drain_q;

  logic             start;
  logic             last_hit;
  logic [CNT_W-1:0] cnt_d;

  // Counter never wraps: an all-ones total completes with the count pinned.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  // Start on an op_en rising edge, or back-to-back when op_en stays high
  // through the previous done pulse; final-atomic detect; next count.
  always_comb begin
    start    = bus.reg2dp_op_en & (~op_en_d1_q | done_d1_q);
    last_hit = (cnt_q == total_q);
    cnt_d    = sat_inc(cnt_q);
  end

  // Layer FSM with registered status outputs.
  always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
    if (!nvdla_core_rstn) begin
      state_q    <= IDLE;
      op_en_d1_q <= 1'b0;
      done_d1_q  <= 1'b0;
      done_q     <= 1'b0;
      busy_q     <= 1'b0;
      err_q      <= 1'b0;
      cnt_q      <= '0;
      total_q    <= '0;
      drain_q    <= '0;
    end else begin
      op_en_d1_q <= bus.reg2dp_op_en;
      done_d1_q  <= done_q;
      done_q     <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            state_q <= RUN;
            busy_q  <= 1'b1;
            total_q <= bus.reg2dp_atomics_total;
            cnt_q   <= '0;
            // An atomic arriving before the layer is running is still a fault.
            err_q   <= bus.mac_out_pvld;
          end else if (bus.mac_out_pvld) begin
            err_q <= 1'b1;
          end
        end
        RUN: begin
          if (bus.mac_out_pvld) begin
            cnt_q <= cnt_d;
            if (last_hit) begin
              state_q <= DRAIN;
              drain_q <= DRAIN_LOAD;
              if (!bus.mac_out_layer_end) err_q <= 1'b1;
            end else if (bus.mac_out_layer_end) begin
              err_q <= 1'b1;
            end
          end
        end
        DRAIN: begin
          if (bus.mac_out_pvld) err_q <= 1'b1;
          if (drain_q == 3'd0) begin
            state_q <= DONE;
            done_q  <= 1'b1;
            busy_q  <= 1'b0;
          end else begin
            drain_q <= drain_q - 3'd1;
          end
        end
        DONE: begin
          if (bus.mac_out_pvld) err_q <= 1'b1;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.dp2reg_done    = done_q;
  assign bus.core_busy      = busy_q;
  assign bus.dp2reg_out_cnt = cnt_q;
  assign bus.dp2reg_err     = err_q;

endmodule

// File: tb/tb_cmac_core_done_tracker.sv
// Bench for cmac_core_done_tracker: three instances (drain 4/1/7, counter
// widths 22/3/3) share one stimulus stream and are compared every cycle
// against an event-scheduled reference model; a vector table and directed
// sequences add fixed expectations for the main instance.
module tb_cmac_core_done_tracker;

  localparam int ND = 3;

  logic        clk = 1'b0;
  logic        rstn;
  logic        op_en;
  logic [21:0] total;
  logic        pvld;
  logic        le;

  int n_total = 0;
  int n_bad   = 0;

  always #5 clk = ~clk;

  cmac_core_done_tracker_if #(.CNT_W(22)) if_a ();
  cmac_core_done_tracker_if #(.CNT_W(3))  if_b ();
  cmac_core_done_tracker_if #(.CNT_W(3))  if_c ();

  assign if_a.reg2dp_op_en = op_en;
  assign if_a.reg2dp_atomics_total = total;
  assign if_a.mac_out_pvld = pvld;
  assign if_a.mac_out_layer_end = le;
  assign if_b.reg2dp_op_en = op_en;
  assign if_b.reg2dp_atomics_total = total[2:0];
  assign if_b.mac_out_pvld = pvld;
  assign if_b.mac_out_layer_end = le;
  assign if_c.reg2dp_op_en = op_en;
  assign if_c.reg2dp_atomics_total = total[2:0];
  assign if_c.mac_out_pvld = pvld;
  assign if_c.mac_out_layer_end = le;

  cmac_core_done_tracker #(.DRAIN_CYC(4), .CNT_W(22)) u_a (
    .nvdla_core_clk(clk), .nvdla_core_rstn(rstn), .bus(if_a));
  cmac_core_done_tracker #(.DRAIN_CYC(1), .CNT_W(3)) u_b (
    .nvdla_core_clk(clk), .nvdla_core_rstn(rstn), .bus(if_b));
  cmac_core_done_tracker #(.DRAIN_CYC(7), .CNT_W(3)) u_c (
    .nvdla_core_clk(clk), .nvdla_core_rstn(rstn), .bus(if_c));

  function automatic int dcyc(input int k);
    return (k == 0) ? 4 : ((k == 1) ? 1 : 7);
  endfunction

  function automatic longint cmask(input int k);
    return (k == 0) ? 64'h3FFFFF : 64'h7;
  endfunction

  // ---------------- reference model ----------------
  // Each layer is described by its running count and the cycle index of
  // its final atomic (m_lf); drain, done and busy follow from cycle offsets.
  longint m_cnt[ND], m_tot[ND], m_lf[ND];
  bit     m_run[ND], m_err[ND], m_pdone[ND];
  bit     m_pop;
  longint t = 0;
  int     gap[ND];

  task automatic model_reset();
    for (int k = 0; k < ND; k++) begin
      m_cnt[k] = 0; m_tot[k] = 0; m_lf[k] = -1000;
      m_run[k] = 0; m_err[k] = 0; m_pdone[k] = 0;
    end
    m_pop = 0;
  endtask

  // Advance the model across one rising edge using the currently driven inputs.
  task automatic model_update();
    for (int k = 0; k < ND; k++) begin
      bit idle, cur_done, start, was_run;
      longint dc;
      dc       = longint'(dcyc(k));
      cur_done = (t == m_lf[k] + dc + 1);
      idle     = !m_run[k] && !(t > m_lf[k] && t <= m_lf[k] + dc + 1);
      start    = idle && op_en && (!m_pop || m_pdone[k]);
      was_run  = m_run[k];
      if (was_run && pvld) begin
        if (m_cnt[k] == m_tot[k]) begin
          if (!le) m_err[k] = 1;
          m_run[k] = 0;
          m_lf[k]  = t;
        end else if (le) begin
          m_err[k] = 1;
        end
        m_cnt[k] = m_cnt[k] + 1;
      end
      if (start) begin
        m_run[k] = 1;
        m_cnt[k] = 0;
        m_tot[k] = longint'(total) & cmask(k);
        m_err[k] = 0;
      end
      if (!was_run && pvld) m_err[k] = 1;
      m_pdone[k] = cur_done;
    end
    m_pop = op_en;
    t = t + 1;
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic get_out(input int k, output logic d, output logic b,
                         output logic [63:0] c, output logic e);
    case (k)
      0: begin d = if_a.dp2reg_done; b = if_a.core_busy; c = 64'(if_a.dp2reg_out_cnt); e = if_a.dp2reg_err; end
      1: begin d = if_b.dp2reg_done; b = if_b.core_busy; c = 64'(if_b.dp2reg_out_cnt); e = if_b.dp2reg_err; end
      default: begin d = if_c.dp2reg_done; b = if_c.core_busy; c = 64'(if_c.dp2reg_out_cnt); e = if_c.dp2reg_err; end
    endcase
  endtask

  // Outputs packed as {cnt, done, busy, err}.
  function automatic logic [63:0] pack(input logic d, input logic b,
                                       input logic [63:0] c, input logic e);
    return {c[60:0], d, b, e};
  endfunction

  task automatic model_check();
    for (int k = 0; k < ND; k++) begin
      logic d, b, e;
      logic [63:0] c;
      longint dc, ec;
      bit ed, eb;
      dc = longint'(dcyc(k));
      ed = (t == m_lf[k] + dc + 1);
      eb = m_run[k] || (t > m_lf[k] && t <= m_lf[k] + dc);
      ec = (m_cnt[k] > cmask(k)) ? cmask(k) : m_cnt[k];
      get_out(k, d, b, c, e);
      check($sformatf("model dut%0d cyc%0d {cnt,done,busy,err}", k, t),
            pack(d, b, c, e), pack(ed, eb, 64'(ec), m_err[k]));
    end
  endtask

  // One cycle: check registered outputs at the falling edge, then drive.
  task automatic step(input bit op, input logic [21:0] tot, input bit pv, input bit le_i);
    @(negedge clk);
    model_check();
    op_en = op; total = tot; pvld = pv; le = le_i;
    model_update();
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0);
  endtask

  // Run 40 quiet cycles and record, per instance, how many cycles after the
  // last driven cycle the first done pulse appears (-1 if none).
  task automatic wait_all();
    for (int k = 0; k < ND; k++) gap[k] = -1;
    for (int i = 1; i <= 40; i++) begin
      step(0, 0, 0, 0);
      if (if_a.dp2reg_done === 1'b1 && gap[0] < 0) gap[0] = i;
      if (if_b.dp2reg_done === 1'b1 && gap[1] < 0) gap[1] = i;
      if (if_c.dp2reg_done === 1'b1 && gap[2] < 0) gap[2] = i;
    end
  endtask

  task automatic do_reset(input string name);
    @(negedge clk);
    model_check();
    rstn = 0; op_en = 0; total = 0; pvld = 0; le = 0;
    #1;
    for (int k = 0; k < ND; k++) begin
      logic d, b, e;
      logic [63:0] c;
      get_out(k, d, b, c, e);
      check($sformatf("%s dut%0d outputs", name, k), pack(d, b, c, e), 64'd0);
    end
    model_reset();
    @(negedge clk);
    rstn = 1;
    model_update();
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    bit          op;
    logic [21:0] tot;
    bit          pv;
    bit          le;
    bit          d;
    bit          b;
    logic [21:0] c;
    bit          e;
  } vec_t;

  vec_t tv[29];

  initial begin
    logic d, b, e;
    logic [63:0] c;
    bit cur_op;

    // op,tot,pv,le | done,busy,cnt,err (outputs seen during that cycle)
    tv[0]  = '{0, 0, 0, 0, 0, 0, 0, 0};
    tv[1]  = '{1, 3, 0, 0, 0, 0, 0, 0};
    tv[2]  = '{1, 3, 1, 0, 0, 1, 0, 0};
    tv[3]  = '{1, 3, 1, 0, 0, 1, 1, 0};
    tv[4]  = '{1, 3, 1, 0, 0, 1, 2, 0};
    tv[5]  = '{1, 3, 1, 1, 0, 1, 3, 0};
    tv[6]  = '{0, 0, 0, 0, 0, 1, 4, 0};
    tv[7]  = '{0, 0, 0, 0, 0, 1, 4, 0};
    tv[8]  = '{0, 0, 0, 0, 0, 1, 4, 0};
    tv[9]  = '{0, 0, 0, 0, 0, 1, 4, 0};
    tv[10] = '{0, 0, 0, 0, 1, 0, 4, 0};
    tv[11] = '{0, 0, 1, 0, 0, 0, 4, 0};
    tv[12] = '{0, 0, 0, 0, 0, 0, 4, 1};
    tv[13] = '{1, 0, 0, 0, 0, 0, 4, 1};
    tv[14] = '{1, 0, 1, 1, 0, 1, 0, 0};
    tv[15] = '{1, 0, 0, 0, 0, 1, 1, 0};
    tv[16] = '{1, 0, 0, 0, 0, 1, 1, 0};
    tv[17] = '{1, 0, 0, 0, 0, 1, 1, 0};
    tv[18] = '{1, 0, 0, 0, 0, 1, 1, 0};
    tv[19] = '{1, 0, 0, 0, 1, 0, 1, 0};
    tv[20] = '{1, 1, 0, 0, 0, 0, 1, 0};
    tv[21] = '{0, 1, 1, 0, 0, 1, 0, 0};
    tv[22] = '{0, 1, 1, 1, 0, 1, 1, 0};
    tv[23] = '{0, 0, 0, 0, 0, 1, 2, 0};
    tv[24] = '{0, 0, 0, 0, 0, 1, 2, 0};
    tv[25] = '{0, 0, 0, 0, 0, 1, 2, 0};
    tv[26] = '{0, 0, 0, 0, 0, 1, 2, 0};
    tv[27] = '{0, 0, 0, 0, 1, 0, 2, 0};
    tv[28] = '{0, 0, 0, 0, 0, 0, 2, 0};

    rstn = 0; op_en = 0; total = 0; pvld = 0; le = 0;
    model_reset();
    repeat (2) @(negedge clk);
    for (int k = 0; k < ND; k++) begin
      get_out(k, d, b, c, e);
      check($sformatf("reset dut%0d outputs", k), pack(d, b, c, e), 64'd0);
    end
    rstn = 1;
    model_update();

    // Single layer, pvld in idle, back-to-back layers with op_en held high.
    for (int i = 0; i < 29; i++) begin
      step(tv[i].op, tv[i].tot, tv[i].pv, tv[i].le);
      get_out(0, d, b, c, e);
      check($sformatf("vec%0d {cnt,done,busy,err}", i), pack(d, b, c, e),
            pack(tv[i].d, tv[i].b, 64'(tv[i].c), tv[i].e));
    end

    // Early layer_end on the 3rd of six atomics; op_en dropped mid-layer.
    idle_cycles(10);
    step(1, 5, 0, 0);
    step(0, 5, 1, 0);
    step(0, 5, 1, 0);
    step(0, 5, 1, 1);
    step(0, 5, 1, 0);
    check("early layer_end err", 64'(if_a.dp2reg_err), 64'd1);
    step(0, 5, 1, 0);
    step(0, 5, 1, 0);
    wait_all();
    check("early layer_end done gap", 64'(gap[0]), 64'd5);
    check("early layer_end cnt", 64'(if_a.dp2reg_out_cnt), 64'd6);
    check("early layer_end err held", 64'(if_a.dp2reg_err), 64'd1);

    // Single-atomic layer: drain lengths 4, 1 and 7.
    idle_cycles(10);
    step(1, 0, 0, 0);
    step(0, 0, 1, 1);
    wait_all();
    check("drain4 done gap", 64'(gap[0]), 64'd5);
    check("drain1 done gap", 64'(gap[1]), 64'd2);
    check("drain7 done gap", 64'(gap[2]), 64'd8);

    // Reset while draining discards the layer; next layer is clean.
    idle_cycles(10);
    step(1, 0, 0, 0);
    step(0, 0, 1, 1);
    step(0, 0, 0, 0);
    step(0, 0, 0, 0);
    check("busy before drain reset", 64'(if_a.core_busy), 64'd1);
    do_reset("drain reset");
    wait_all();
    check("no done after reset", 64'(gap[0]), 64'hFFFF_FFFF_FFFF_FFFF);
    step(1, 2, 0, 0);
    step(0, 2, 1, 0);
    step(0, 2, 1, 0);
    step(0, 2, 1, 1);
    wait_all();
    check("post reset done gap", 64'(gap[0]), 64'd5);
    check("post reset cnt", 64'(if_a.dp2reg_out_cnt), 64'd3);
    check("post reset err", 64'(if_a.dp2reg_err), 64'd0);

    // Saturation on the 3-bit instances: total 7 completes at count 7.
    idle_cycles(10);
    step(1, 7, 0, 0);
    for (int i = 0; i < 8; i++) step(0, 7, 1, (i == 7));
    wait_all();
    check("sat cnt dut1", 64'(if_b.dp2reg_out_cnt), 64'd7);
    check("sat err dut1", 64'(if_b.dp2reg_err), 64'd0);
    check("sat done gap dut1", 64'(gap[1]), 64'd2);

    // Random traffic against the model.
    cur_op = 0;
    for (int i = 0; i < 3000; i++) begin
      bit pv, l;
      if ($urandom_range(15) == 0) cur_op = !cur_op;
      pv = ($urandom_range(1) == 1);
      l  = pv ? ($urandom_range(3) == 0) : ($urandom_range(4) == 0);
      if ($urandom_range(499) == 0) do_reset("random reset");
      else step(cur_op, 22'($urandom_range(15)), pv, l);
    end
    idle_cycles(2);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
